midi_voice_allocator: RTL and testbench

Polyphonic voice scheduler that sits between `midi_uart` and the bank of `voice` instances in the MIDI player. It consumes framed MIDI events over the valid/ack handshake and decides which voice plays each note. It drives each voice's gate, note and tone frequency, steals the least-recently-triggered voice when all are busy, and retriggers the envelope cleanly with a guaranteed gate-low gap.

---
 rtl/midi_voice_allocator.sv | 271 +++++++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
// Polyphonic voice scheduler between the MIDI UART framer and the voice bank.
// Each framed MIDI event is taken over a valid/ack handshake. The block then
// decides which voice plays the note. It drives that voice's gate, note number
// and tone frequency. When every voice is busy it steals the least-recently
// triggered voice. A gated voice is always retriggered through a gate-low gap
// so its envelope restarts cleanly.
//
// Optional feature macro: MIDI_ALLOC_SUSTAIN_PEDAL_EN
//   When defined, controller 0x40 (sustain pedal) is honoured. While the pedal
//   is down, note-offs are deferred. Releasing the pedal gates off every
//   deferred voice.
//
// Tone frequency: for note n, octave o = n/12 and semitone k = n%12. The value
// is base[k] >> (10-o), where base[k] = round(4 * f(120+k)) and
// f(m) = 440 * 2^((m-69)/12). This is the note frequency in quarter-Hz, with
// lower octaves obtained by shifting the top-octave value.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   midi_event_valid  framed MIDI event available
//   midi_command      status byte (channel nibble ignored, omni)
//   midi_parameter_1  note number / controller number
//   midi_parameter_2  velocity / controller value
//   midi_event_ack    one-cycle event acknowledge
//   voice_gate        per-voice gate
//   voice_note        note of voice i at [7i+6:7i]
//   voice_frequency   tone frequency of voice i at [16i+15:16i]
//   busy              high whenever the scheduler is not idle
module midi_voice_allocator #(
    parameter int NUM_VOICES      = 4,
    parameter int GATE_LOW_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     midi_event_valid,
    input  logic [7:0]               midi_command,
    input  logic [6:0]               midi_parameter_1,
    input  logic [6:0]               midi_parameter_2,
    output logic                     midi_event_ack,
    output logic [NUM_VOICES-1:0]    voice_gate,
    output logic [7*NUM_VOICES-1:0]  voice_note,
    output logic [16*NUM_VOICES-1:0] voice_frequency,
    output logic                     busy
);
    localparam int AW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(GATE_LOW_CYCLES + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VOICES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GATE_LOW_CYCLES);
    localparam logic [3:0] CMD_NOTE_OFF = 4'h8;
    localparam logic [3:0] CMD_NOTE_ON  = 4'h9;
    localparam logic [3:0] CMD_CC       = 4'hB;

    typedef enum logic [2:0] {IDLE, SCAN, DECIDE, RETRIG, APPLY, ACK} state_t;

    state_t          state_q;
    logic [3:0]      cmd_q;
    logic [6:0]      p1_q;
    logic [6:0]      p2_q;
    logic [AW-1:0]   scan_idx_q;
    logic [AW-1:0]   target_q;
    logic [AW-1:0]   target_d;
    logic            match_found_q;
    logic [AW-1:0]   match_idx_q;
    logic            free_found_q;
    logic [AW-1:0]   free_idx_q;
    logic [AW-1:0]   free_age_q;
    logic [AW-1:0]   oldest_idx_q;
    logic [CW-1:0]   cnt_q;
    logic            ack_q;
    logic            busy_q;
    logic [NUM_VOICES-1:0] gate_q;
    logic [6:0]      note_q [NUM_VOICES];
    logic [15:0]     freq_q [NUM_VOICES];
    logic [AW-1:0]   age_q  [NUM_VOICES];
    logic [15:0]     lookup_d;
`ifdef MIDI_ALLOC_SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0] sus_q;
    logic                  pedal_q;
`endif

    // Omni mode: the channel nibble is deliberately not used.
    logic unused_chan;
    assign unused_chan = ^midi_command[3:0];

    function automatic logic [15:0] tone_freq(input logic [6:0] note);
        logic [6:0]  octave;
        logic [6:0]  semi;
        logic [15:0] base;
        octave = note / 7'd12;
        semi   = note - octave * 7'd12;
        case (semi)
            7'd0:    base = 16'd33488;
            7'd1:    base = 16'd35479;
            7'd2:    base = 16'd37589;
            7'd3:    base = 16'd39824;
            7'd4:    base = 16'd42192;
            7'd5:    base = 16'd44701;
            7'd6:    base = 16'd47359;
            7'd7:    base = 16'd50175;
            7'd8:    base = 16'd53159;
            7'd9:    base = 16'd56320;
            7'd10:   base = 16'd59669;
            7'd11:   base = 16'd63217;
            default: base = 16'd0;
        endcase
        return base >> (7'd10 - octave);
    endfunction

    assign lookup_d = tone_freq(p1_q);

    // Target priority: same gated note, then the longest-idle free voice, then steal.
    always_comb begin
        target_d = oldest_idx_q;
        if (match_found_q) begin
            target_d = match_idx_q;
        end else if (free_found_q) begin
            target_d = free_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            scan_idx_q    <= '0;
            target_q      <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            free_age_q    <= '0;
            oldest_idx_q  <= '0;
            cnt_q         <= '0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            gate_q        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                freq_q[i] <= '0;
                // Voice 0 starts as the oldest so it is allocated first.
                age_q[i]  <= AW'(NUM_VOICES - 1 - i);
            end
`ifdef MIDI_ALLOC_SUSTAIN_PEDAL_EN
            sus_q   <= '0;
            pedal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (midi_event_valid && !ack_q) begin
                        cmd_q         <= midi_command[7:4];
                        p1_q          <= midi_parameter_1;
                        p2_q          <= midi_parameter_2;
                        scan_idx_q    <= '0;
                        match_found_q <= 1'b0;
                        free_found_q  <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= SCAN;
                    end
                end
                SCAN: begin
                    if (gate_q[scan_idx_q] && note_q[scan_idx_q] == p1_q && !match_found_q) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= scan_idx_q;
                    end
                    if (!gate_q[scan_idx_q] &&
                        (!free_found_q || age_q[scan_idx_q] > free_age_q)) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= scan_idx_q;
                        free_age_q   <= age_q[scan_idx_q];
                    end
                    if (age_q[scan_idx_q] == LAST_IDX) begin
                        oldest_idx_q <= scan_idx_q;
                    end
                    scan_idx_q <= scan_idx_q + 1'b1;
                    if (scan_idx_q == LAST_IDX) begin
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                    if (cmd_q == CMD_NOTE_ON && p2_q != '0) begin
                        target_q <= target_d;
                        ack_q    <= 1'b0;
                        if (gate_q[target_d]) begin
                            gate_q[target_d] <= 1'b0;
                            cnt_q            <= GAP_LOAD;
                            state_q          <= RETRIG;
                        end else begin
                            state_q <= APPLY;
                        end
                    end else if (cmd_q == CMD_NOTE_OFF || cmd_q == CMD_NOTE_ON) begin
                        // Note and frequency stay put so the release phase keeps its pitch.
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (gate_q[i] && note_q[i] == p1_q) begin
`ifdef MIDI_ALLOC_SUSTAIN_PEDAL_EN
                                if (pedal_q) begin
                                    sus_q[i] <= 1'b1;
                                end else begin
                                    gate_q[i] <= 1'b0;
                                end
`else
                                gate_q[i] <= 1'b0;
`endif
                            end
                        end
                    end else if (cmd_q == CMD_CC && p1_q == 7'h7B) begin
                        gate_q <= '0;
`ifdef MIDI_ALLOC_SUSTAIN_PEDAL_EN
                        sus_q  <= '0;
                    end else if (cmd_q == CMD_CC && p1_q == 7'h40) begin
                        pedal_q <= p2_q[6];
                        if (!p2_q[6]) begin
                            gate_q <= gate_q & ~sus_q;
                            sus_q  <= '0;
                        end
`endif
                    end
                end
                RETRIG: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    note_q[target_q] <= p1_q;
                    freq_q[target_q] <= lookup_d;
                    gate_q[target_q] <= 1'b1;
`ifdef MIDI_ALLOC_SUSTAIN_PEDAL_EN
                    sus_q[target_q]  <= 1'b0;
`endif
                    // Shift every younger voice back by one; ages stay a permutation.
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (age_q[i] < age_q[target_q]) begin
                            age_q[i] <= age_q[i] + 1'b1;
                        end
                    end
                    age_q[target_q] <= '0;
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign midi_event_ack = ack_q;
    assign busy           = busy_q;
    assign voice_gate     = gate_q;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
            assign voice_note[7*gi +: 7]       = note_q[gi];
            assign voice_frequency[16*gi +: 16] = freq_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed testbench for midi_voice_allocator (4 voices, 32-cycle gate gap).
// Each event pushes its expected voice state to a scoreboard queue. The entry
// is popped and compared in the cycle the allocator acknowledges the event.
module tb_midi_voice_allocator;
    localparam int NV  = 4;
    localparam int GAP = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          midi_event_valid;
    logic [7:0]    midi_command;
    logic [6:0]    midi_parameter_1;
    logic [6:0]    midi_parameter_2;
    logic          midi_event_ack;
    logic [NV-1:0] voice_gate;
    logic [7*NV-1:0]  voice_note;
    logic [16*NV-1:0] voice_frequency;
    logic          busy;

    midi_voice_allocator #(.NUM_VOICES(NV), .GATE_LOW_CYCLES(GAP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .midi_event_valid (midi_event_valid),
        .midi_command     (midi_command),
        .midi_parameter_1 (midi_parameter_1),
        .midi_parameter_2 (midi_parameter_2),
        .midi_event_ack   (midi_event_ack),
        .voice_gate       (voice_gate),
        .voice_note       (voice_note),
        .voice_frequency  (voice_frequency),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0] gate;
        int            voice;
        int            note;
        int            freq;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Quarter-Hz note frequency: top-octave value rounded, shifted down per octave.
    function automatic int exp_freq(input int n);
        int  o;
        int  k;
        real base;
        o    = n / 12;
        k    = n % 12;
        base = 28160.0 * (2.0 ** ((3.0 + k) / 12.0));
        return $rtoi(base + 0.5) >> (10 - o);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        midi_event_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
    endtask

    // Send one event and watch voice wv. Cycle c=0 is t0, the first valid cycle.
    task automatic send(input string tag, input logic [7:0] cmd, input int p1, input int p2,
                        input int wv, input logic [NV-1:0] egate, input int enote,
                        output int fall_c, output int rise_c, output int ack_c);
        exp_t e;
        exp_t got;
        logic prev;
        e.gate  = egate;
        e.voice = wv;
        e.note  = enote;
        e.freq  = (enote == 0) ? 0 : exp_freq(enote);
        @(posedge clk); #1;
        midi_event_valid = 1'b1;
        midi_command     = cmd;
        midi_parameter_1 = 7'(p1);
        midi_parameter_2 = 7'(p2);
        sb_q.push_back(e);
        fall_c = -1;
        rise_c = -1;
        ack_c  = -1;
        prev   = voice_gate[wv];
        for (int c = 0; c < 200 && ack_c < 0; c++) begin
            @(negedge clk);
            if (prev && !voice_gate[wv] && fall_c < 0) fall_c = c;
            if (!prev && voice_gate[wv] && rise_c < 0) rise_c = c;
            prev = voice_gate[wv];
            if (midi_event_ack) begin
                ack_c = c;
                chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    chk({tag, "_gate"}, 32'(voice_gate), 32'(got.gate));
                    chk({tag, "_note"}, 32'(voice_note[7*got.voice +: 7]), 32'(got.note));
                    chk({tag, "_freq"}, 32'(voice_frequency[16*got.voice +: 16]), 32'(got.freq));
                end
            end
        end
        chk({tag, "_ack_seen"}, 32'(ack_c >= 0), 32'd1);
        // Valid stays high through the ack cycle; it must not be taken twice.
        @(posedge clk); #1;
        midi_event_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_single"}, 32'(midi_event_ack), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        $display("event %s cmd=%02h p1=%0d p2=%0d fall=%0d rise=%0d ack=%0d gate=%b",
                 tag, cmd, p1, p2, fall_c, rise_c, ack_c, voice_gate);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f;
        int r;
        int a;
        int ack_hits;
        rst_n            = 1'b0;
        midi_event_valid = 1'b0;
        midi_command     = '0;
        midi_parameter_1 = '0;
        midi_parameter_2 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_gate", 32'(voice_gate), 32'd0);
        chk("rst_ack", 32'(midi_event_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_note", 32'(voice_note != '0), 32'd0);
        chk("rst_freq", 32'(voice_frequency != '0), 32'd0);

        // First note goes to voice 0; gate rises 7 cycles after valid.
        send("on60", 8'h90, 60, 100, 0, 4'b0001, 60, f, r, a);
        chk("on60_rise", 32'(r), 32'd7);
        chk("on60_ack", 32'(a), 32'd7);

        // Note-off keeps note; the next note-on uses the oldest free voice (1).
        send("off60", 8'h80, 60, 0, 0, 4'b0000, 60, f, r, a);
        chk("off60_fall", 32'(f), 32'd6);
        chk("off60_ack", 32'(a), 32'd6);
        send("on60b", 8'h90, 60, 100, 1, 4'b0010, 60, f, r, a);
        chk("on60b_rise", 32'(r), 32'd7);
        send("on60v0", 8'h90, 60, 0, 1, 4'b0000, 60, f, r, a);
        chk("on60v0_fall", 32'(f), 32'd6);

        // Retrigger of an already gated note reuses its voice (2) with a 33-cycle gap.
        send("on60c", 8'h90, 60, 100, 2, 4'b0100, 60, f, r, a);
        chk("on60c_rise", 32'(r), 32'd7);
        send("retrig60", 8'h90, 60, 90, 2, 4'b0100, 60, f, r, a);
        chk("retrig60_fall", 32'(f), 32'd6);
        chk("retrig60_low", 32'(r - f), 32'(GAP + 1));
        chk("retrig60_ack", 32'(a), 32'(GAP + 7));

        // Fill all voices, then steal the oldest twice.
        do_reset();
        send("fill60", 8'h90, 60, 100, 0, 4'b0001, 60, f, r, a);
        send("fill62", 8'h90, 62, 100, 1, 4'b0011, 62, f, r, a);
        send("fill64", 8'h90, 64, 100, 2, 4'b0111, 64, f, r, a);
        send("fill65", 8'h90, 65, 100, 3, 4'b1111, 65, f, r, a);
        send("steal67", 8'h90, 67, 100, 0, 4'b1111, 67, f, r, a);
        chk("steal67_fall", 32'(f), 32'd6);
        chk("steal67_low", 32'(r - f), 32'(GAP + 1));
        // Voice 1 aged to oldest after the steal, so it is the next victim.
        send("steal72", 8'h90, 72, 100, 1, 4'b1111, 72, f, r, a);
        chk("steal72_fall", 32'(f), 32'd6);
        chk("steal72_rise", 32'(r), 32'(GAP + 7));

        // All notes off, then an unhandled command.
        do_reset();
        send("a60", 8'h90, 60, 100, 0, 4'b0001, 60, f, r, a);
        send("a62", 8'h90, 62, 100, 1, 4'b0011, 62, f, r, a);
        send("a64", 8'h90, 64, 100, 2, 4'b0111, 64, f, r, a);
        send("alloff", 8'hB0, 8'h7B, 0, 0, 4'b0000, 60, f, r, a);
        chk("alloff_fall", 32'(f), 32'd6);
        chk("alloff_ack", 32'(a), 32'd6);
        send("pgm", 8'hC0, 5, 0, 2, 4'b0000, 64, f, r, a);
        chk("pgm_ack", 32'(a), 32'd6);

        // Reset in the middle of a retrigger gap drops the event without ack.
        do_reset();
        send("r60", 8'h90, 60, 100, 0, 4'b0001, 60, f, r, a);
        @(posedge clk); #1;
        midi_event_valid = 1'b1;
        midi_command     = 8'h90;
        midi_parameter_1 = 7'd60;
        midi_parameter_2 = 7'd100;
        repeat (12) @(posedge clk);
        #1;
        chk("midgap_gate", 32'(voice_gate), 32'd0);
        chk("midgap_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        midi_event_valid = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_note", 32'(voice_note != '0), 32'd0);
        ack_hits = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 5) rst_n = 1'b1;
            if (midi_event_ack) ack_hits++;
        end
        chk("dropped_no_ack", 32'(ack_hits), 32'd0);
        chk("dropped_gate", 32'(voice_gate), 32'd0);
        $display("event reset_mid_retrig ack_hits=%0d gate=%b", ack_hits, voice_gate);
        sb_q.delete();

`ifdef MIDI_ALLOC_SUSTAIN_PEDAL_EN
        do_reset();
        send("ped_dn", 8'hB0, 8'h40, 127, 0, 4'b0000, 0, f, r, a);
        send("ped_on", 8'h90, 60, 100, 0, 4'b0001, 60, f, r, a);
        send("ped_off", 8'h80, 60, 0, 0, 4'b0001, 60, f, r, a);
        chk("ped_off_held", 32'(f), 32'hFFFF_FFFF);
        send("ped_up", 8'hB0, 8'h40, 0, 0, 4'b0000, 60, f, r, a);
        chk("ped_up_fall", 32'(f), 32'd6);
`else
        do_reset();
        send("cc64_on", 8'h90, 60, 100, 0, 4'b0001, 60, f, r, a);
        send("cc64_ign", 8'hB0, 8'h40, 127, 0, 4'b0001, 60, f, r, a);
        send("cc64_off", 8'h80, 60, 0, 0, 4'b0000, 60, f, r, a);
        chk("cc64_off_fall", 32'(f), 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
